// File: rtl/usr_pkg.sv
// Shared types for the universal shift register.
// USR_ROTATE_EN enables the ROR/ROL modes; without it those modes behave as HOLD.
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'd0,
        MODE_SHR   = 3'd1,
        MODE_SHL   = 3'd2,
        MODE_LOAD  = 3'd3,
        MODE_ROR   = 3'd4,
        MODE_ROL   = 3'd5,
        MODE_ASR   = 3'd6,
        MODE_CLEAR = 3'd7
    } usr_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } usr_state_e;

    function automatic logic is_step_mode(input usr_mode_e m);
        case (m)
            MODE_SHR, MODE_SHL, MODE_ASR: is_step_mode = 1'b1;
`ifdef USR_ROTATE_EN
            MODE_ROR, MODE_ROL:           is_step_mode = 1'b1;
`endif
            default:                      is_step_mode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/usr_step_logic.sv
// One shift/rotate step: next register value and the bit leaving the register.
// Rotate paths exist only when USR_ROTATE_EN is defined.
module usr_step_logic
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] value,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    output logic [WIDTH-1:0] next_value,
    output logic             out_bit
);

    always_comb begin
        next_value = value;
        out_bit    = 1'b0;
        case (mode)
            MODE_SHR: begin
                next_value = {ser_in_l, value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            MODE_SHL: begin
                next_value = {value[WIDTH-2:0], ser_in_r};
                out_bit    = value[WIDTH-1];
            end
            MODE_ASR: begin
                next_value = {value[WIDTH-1], value[WIDTH-1:1]};
                out_bit    = value[0];
            end
`ifdef USR_ROTATE_EN
            MODE_ROR: begin
                next_value = {value[0], value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            MODE_ROL: begin
                next_value = {value[WIDTH-2:0], value[WIDTH-1]};
                out_bit    = value[WIDTH-1];
            end
`endif
            default: begin
                next_value = value;
                out_bit    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/param_universal_shift_reg.sv
// Parametrised universal shift register with command handshake and repeat count.
// USR_ROTATE_EN selects whether modes 4/5 rotate or act as HOLD.
//
// state | meaning
// IDLE  | ready for a command; single-step commands complete at the accept edge
// RUN   | steps 2..N of a multi-step command executing, one per edge
module param_universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    output logic [WIDTH-1:0] parallel_q,
    output logic             serial_q,
    output logic             busy,
    output logic             done
);

    usr_state_e       state, state_next;
    usr_mode_e        mode_q, mode_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] pq_next;
    logic             sq_next;
    logic             done_next;
    logic             accept;
    usr_mode_e        step_mode;
    logic [WIDTH-1:0] step_value;
    logic             step_bit;

    assign busy      = (state == RUN);
    assign cmd_ready = ~busy;
    assign accept    = cmd_valid & cmd_ready;
    assign step_mode = (state == RUN) ? mode_q : usr_mode_e'(cmd_mode);

    usr_step_logic #(.WIDTH(WIDTH)) u_step (
        .mode       (step_mode),
        .value      (parallel_q),
        .ser_in_l   (ser_in_l),
        .ser_in_r   (ser_in_r),
        .next_value (step_value),
        .out_bit    (step_bit)
    );

    always_comb begin
        state_next = state;
        mode_next  = mode_q;
        cnt_next   = cnt;
        pq_next    = parallel_q;
        sq_next    = serial_q;
        done_next  = 1'b0;
        if (state == RUN) begin
            pq_next = step_value;
            sq_next = step_bit;
            // cnt holds the steps still to run; reaching 1 means this edge is step N
            if (cnt == CNT_W'(1)) begin
                state_next = IDLE;
                done_next  = 1'b1;
            end else begin
                cnt_next = cnt - CNT_W'(1);
            end
        end else if (accept) begin
            done_next = 1'b1;
            mode_next = usr_mode_e'(cmd_mode);
            case (usr_mode_e'(cmd_mode))
                MODE_LOAD:  pq_next = data_in;
                MODE_CLEAR: pq_next = '0;
                default: begin
                    if (is_step_mode(usr_mode_e'(cmd_mode)) && cmd_count != '0) begin
                        pq_next = step_value;
                        sq_next = step_bit;
                        if (cmd_count > CNT_W'(1)) begin
                            state_next = RUN;
                            cnt_next   = cmd_count - CNT_W'(1);
                            done_next  = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mode_q     <= MODE_HOLD;
            cnt        <= '0;
            parallel_q <= '0;
            serial_q   <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            mode_q     <= mode_next;
            cnt        <= cnt_next;
            parallel_q <= pq_next;
            serial_q   <= sq_next;
            done       <= done_next;
        end
    end

endmodule

// File: tb/tb_param_universal_shift_reg.sv
// Directed self-checking bench for param_universal_shift_reg (WIDTH=8, CNT_W=4).
// Expectations for modes 4/5 follow USR_ROTATE_EN as seen by this compile.
module tb_param_universal_shift_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_mode = 3'd0;
    logic [3:0] cmd_count = 4'd0;
    logic [7:0] data_in = 8'h00;
    logic       ser_in_l = 1'b0;
    logic       ser_in_r = 1'b0;
    logic [7:0] parallel_q;
    logic       serial_q;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_universal_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_count  (cmd_count),
        .data_in    (data_in),
        .ser_in_l   (ser_in_l),
        .ser_in_r   (ser_in_r),
        .parallel_q (parallel_q),
        .serial_q   (serial_q),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command and wait for done; edges counts the accept edge as 1.
    task automatic run_cmd(input logic [2:0] mode, input logic [3:0] count,
                           input logic [7:0] data, output int edges, output int busy_cyc);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_mode  = mode;
        cmd_count = count;
        data_in   = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        edges     = 1;
        busy_cyc  = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cyc++;
            @(posedge clk);
            #1;
            edges++;
        end
        check("done_seen", done, 1'b1);
    endtask

    int edges, bcyc, done_cnt;

    initial begin
        #12;
        check("rst_pq", parallel_q, 8'h00);
        check("rst_sq", serial_q, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ready", cmd_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;

        // reset mid-RUN
        run_cmd(3'd3, 4'd0, 8'h81, edges, bcyc);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_mode = 3'd4; cmd_count = 4'd10;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
`ifdef USR_ROTATE_EN
        check("ror3_pq", parallel_q, 8'h30);
        check("ror3_busy", busy, 1'b1);
`else
        check("ror_hold_pq", parallel_q, 8'h81);
        check("ror_hold_busy", busy, 1'b0);
`endif
        #2;
        rst = 1'b0;
        #1;
        check("abort_pq", parallel_q, 8'h00);
        check("abort_sq", serial_q, 1'b0);
        check("abort_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);

        // LOAD
        run_cmd(3'd3, 4'd0, 8'hA5, edges, bcyc);
        check("load_pq", parallel_q, 8'hA5);
        check("load_lat", edges, 1);
        check("load_busy", bcyc, 0);
        @(posedge clk); #1;
        check("load_done_1cyc", done, 1'b0);

        // SHR N=3 with ser_in_l=1
        ser_in_l = 1'b1;
        run_cmd(3'd1, 4'd3, 8'h00, edges, bcyc);
        ser_in_l = 1'b0;
        check("shr_pq", parallel_q, 8'hF4);
        check("shr_sq", serial_q, 1'b1);
        check("shr_busy", bcyc, 2);
        check("shr_lat", edges, 3);
        @(posedge clk); #1;
        check("shr_done_1cyc", done, 1'b0);

        // ASR N=2
        run_cmd(3'd3, 4'd0, 8'h90, edges, bcyc);
        run_cmd(3'd6, 4'd2, 8'h00, edges, bcyc);
        check("asr_pq", parallel_q, 8'hE4);
        check("asr_sq", serial_q, 1'b0);

        // ROL N=4
        run_cmd(3'd3, 4'd0, 8'h3C, edges, bcyc);
        run_cmd(3'd5, 4'd4, 8'h00, edges, bcyc);
`ifdef USR_ROTATE_EN
        check("rol_pq", parallel_q, 8'hC3);
        check("rol_sq", serial_q, 1'b1);
        check("rol_busy", bcyc, 3);
`else
        check("rol_hold_pq", parallel_q, 8'h3C);
        check("rol_hold_sq", serial_q, 1'b0);
        check("rol_hold_lat", edges, 1);
        check("rol_hold_busy", bcyc, 0);
`endif

        // SHL N=1 with ser_in_r=1 from 0x3C/0xC3
        ser_in_r = 1'b1;
        run_cmd(3'd2, 4'd1, 8'h00, edges, bcyc);
        ser_in_r = 1'b0;
`ifdef USR_ROTATE_EN
        check("shl1_pq", parallel_q, 8'h87);
        check("shl1_sq", serial_q, 1'b1);
`else
        check("shl1_pq", parallel_q, 8'h79);
        check("shl1_sq", serial_q, 1'b0);
`endif
        check("shl1_lat", edges, 1);

        // back-to-back: SHL N=0 held valid during SHR N=4
        run_cmd(3'd3, 4'd0, 8'h8F, edges, bcyc);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_mode = 3'd1; cmd_count = 4'd4;
        @(posedge clk); #1;
        cmd_mode = 3'd2; cmd_count = 4'd0;
        edges = 1;
        while (!done && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        check("b2b_first_lat", edges, 4);
        check("b2b_ready_at_done", cmd_ready, 1'b1);
        check("b2b_pq1", parallel_q, 8'h08);
        check("b2b_sq1", serial_q, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("b2b_done2", done, 1'b1);
        check("b2b_pq2", parallel_q, 8'h08);
        check("b2b_busy2", busy, 1'b0);
        @(posedge clk); #1;
        check("b2b_done_low", done, 1'b0);

        // CLEAR
        run_cmd(3'd7, 4'd0, 8'hFF, edges, bcyc);
        check("clear_pq", parallel_q, 8'h00);
        check("clear_sq", serial_q, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_universal_shift_reg.md
# param_universal_shift_reg

Parametrised universal shift register with a command handshake and multi-step shift/rotate execution. It is the next generation of the team's 4-bit universal shift register: width is configurable, it adds serial inputs, rotate and arithmetic modes, and a repeat count. A controller issues one command at a time and gets a completion pulse when the command finishes. It sits in the sequential datapath library as a generic shift/rotate engine.

## Interface
- WIDTH, 8, register width in bits (≥2)
- CNT_W, 4, width of the repeat-count field
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command; equals !busy
- cmd_mode  in  3  operation code (see Operation)
- cmd_count  in  CNT_W  number of steps for shift/rotate modes
- data_in  in  WIDTH  parallel load value
- ser_in_l  in  1  serial bit entering the MSB on right shifts
- ser_in_r  in  1  serial bit entering the LSB on left shifts
- parallel_q  out  WIDTH  register contents
- serial_q  out  1  last bit shifted or rotated out
- busy  out  1  multi-step command in progress
- done  out  1  one-cycle completion pulse

## Operation
- Modes: 0 HOLD, 1 SHR (logical right, MSB←ser_in_l), 2 SHL (left, LSB←ser_in_r), 3 LOAD, 4 ROR, 5 ROL, 6 ASR (MSB replicated), 7 CLEAR.
- Accept: cmd_valid && cmd_ready at a rising edge. Mode and count are latched; data_in is sampled only at this edge.
- HOLD, LOAD and CLEAR complete at the accept edge. LOAD/CLEAR write parallel_q there; serial_q is unchanged.
- Step modes (1, 2, 4, 5, 6) with count N≥1:
  - step 1 executes at the accept edge; steps 2..N execute on the following edges;
  - ser_in_l/ser_in_r are sampled at each step edge;
  - serial_q is updated at every step (the outgoing bit for SHR/ROR/ASR is LSB, for SHL/ROL it is MSB).
- A step mode with N=0 behaves as HOLD.
- FSM has two states: IDLE and RUN. IDLE→RUN on accepting a step command with N≥2; RUN→IDLE on the edge that executes step N. busy = (state==RUN).
- A command that has not been accepted has no effect.

## Timing
- Reset values: parallel_q=0, serial_q=0, busy=0, done=0, state IDLE. Reset takes effect immediately, regardless of clk.
- Reset asserted mid-RUN aborts the command. The remaining steps are discarded and no done pulse is produced.
- Completion edge: the accept edge for single-step commands, otherwise the edge of step N. done is high for exactly the one cycle after the completion edge.
- busy is high for N−1 cycles.
- cmd_ready is combinational from state. A new command may be accepted in the same cycle that done is high, so back-to-back commands have zero bubbles.
- Latency: N cycles from the accept edge until done is high (N≥1); 1 cycle for HOLD/LOAD/CLEAR/N=0.
- cmd_count is unsigned. The maximum of 2^CNT_W−1 steps applies; there is no modulo on WIDTH, so rotating by WIDTH restores the original value.

## Configuration
- USR_ROTATE_EN defined: modes 4/5 rotate as specified.
- USR_ROTATE_EN undefined: modes 4/5 are accepted and treated as HOLD. They give a single-cycle done pulse, leave parallel_q and serial_q unchanged, and never raise busy. No rotate logic is synthesised.

## Structure
- Shared package usr_pkg holds:
  - enum usr_mode_e (3-bit, values above);
  - FSM state typedef usr_state_e {IDLE, RUN}.
- One sub-module, usr_step_logic: combinational next-value and outgoing-bit calculation for one step of a given mode. It is instantiated once; the top holds the register, counter and FSM.

## Test plan
The checks below use WIDTH=8 and CNT_W=4.

- Reset: start ROR N=10, pull rst low after step 3. Expect immediately parallel_q=0x00, serial_q=0, busy=0, and no done after release.
- LOAD data_in=0xA5. Expect parallel_q=0xA5 after the accept edge, done=1 for one cycle, busy never high.
- From 0xA5: SHR N=3, ser_in_l=1. Expect parallel_q=0xF4, serial_q=1, busy high 2 cycles, done 3 cycles after accept.
- From 0x90: ASR N=2. Expect 0xE4, serial_q=0.
- From 0x3C: ROL N=4. With the macro, expect 0xC3, serial_q=1. Without the macro, expect 0x3C unchanged with a single-cycle done.
- Back-to-back: hold cmd_valid with SHL N=0 during a SHR N=4. Expect acceptance in the cycle done is high, no data change, and a second done pulse one cycle later.
